// File: rtl/uart_host_bridge_if.sv
// Signal bundle between the host bridge and its environment (UART plus host logic).
// The bridge uses the slave modport; whatever drives the UART/host side uses master.
interface uart_host_bridge_if #(
  parameter int unsigned AW = 4
);
  logic          UART_INTR;
  logic [7:0]    UART_DATA_OUT;
  logic          READ_DATA;
  logic          READ_STATUS;
  logic          Tx_load;
  logic [7:0]    OUT_PORT_DATA;
  logic          TX_WR;
  logic [7:0]    TX_WDATA;
  logic          TX_FULL;
  logic [AW:0]   TX_COUNT;
  logic          RX_RD;
  logic [7:0]    RX_RDATA;
  logic          RX_EMPTY;
  logic [AW:0]   RX_COUNT;
  logic [3:0]    ERR_FLAGS;
  logic          ERR_CLR;

  modport master (
    output UART_INTR, UART_DATA_OUT, TX_WR, TX_WDATA, RX_RD, ERR_CLR,
    input  READ_DATA, READ_STATUS, Tx_load, OUT_PORT_DATA, TX_FULL, TX_COUNT,
    input  RX_RDATA, RX_EMPTY, RX_COUNT, ERR_FLAGS
  );

  modport slave (
    input  UART_INTR, UART_DATA_OUT, TX_WR, TX_WDATA, RX_RD, ERR_CLR,
    output READ_DATA, READ_STATUS, Tx_load, OUT_PORT_DATA, TX_FULL, TX_COUNT,
    output RX_RDATA, RX_EMPTY, RX_COUNT, ERR_FLAGS
  );
endinterface

// File: rtl/uart_host_bridge.sv
// Host-side UART controller: TX/RX FIFOs, interrupt-driven status/data FSM and
// sticky receive-error flags.
module uart_host_bridge #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic              clk,
  input logic              reset,
  uart_host_bridge_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStat, StRxrd, StTxld} state_e;

  localparam logic [AW:0] FullCount = DEPTH[AW:0];
  localparam logic [AW:0] OneCount  = 1;

  state_e          state_q, state_d;
  logic            intr_pending_q, intr_pending_d;
  logic            tx_shadow_q, tx_shadow_d;
  logic [3:0]      err_q, err_d;
  logic [7:0]      out_data_q, out_data_d;

  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q, rx_rd_ptr_nxt;
  logic [AW:0]     tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [7:0]      rx_rdata_q, rx_rdata_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_empty      = (tx_count_q == '0);
  assign tx_full       = (tx_count_q == FullCount);
  assign rx_empty      = (rx_count_q == '0);
  assign rx_full       = (rx_count_q == FullCount);
  // A write while full is dropped even if a load pops in the same cycle.
  assign tx_push       = bus.TX_WR && !tx_full;
  assign tx_pop        = (state_q == StTxld);
  assign rx_push       = (state_q == StRxrd) && !rx_full;
  assign rx_pop        = bus.RX_RD && !rx_empty;
  assign rx_rd_ptr_nxt = rx_rd_ptr_q + 1'b1;

  // Next state, strobes, interrupt/shadow bookkeeping and error flags.
  always_comb begin
    state_d         = state_q;
    intr_pending_d  = intr_pending_q;
    tx_shadow_d     = tx_shadow_q;
    err_d           = bus.ERR_CLR ? 4'b0000 : err_q;
    out_data_d      = out_data_q;
    bus.READ_STATUS = 1'b0;
    bus.READ_DATA   = 1'b0;
    bus.Tx_load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (intr_pending_q)                 state_d = StStat;
        else if (tx_shadow_q && !tx_empty)  state_d = StTxld;
      end
      StStat: begin
        bus.READ_STATUS = 1'b1;
        err_d[2:0]      = err_d[2:0] | bus.UART_DATA_OUT[4:2];
        tx_shadow_d     = bus.UART_DATA_OUT[1];
        intr_pending_d  = 1'b0;
        if (bus.UART_DATA_OUT[0])                       state_d = StRxrd;
        else if (bus.UART_DATA_OUT[1] && !tx_empty)     state_d = StTxld;
        else                                            state_d = StIdle;
      end
      StRxrd: begin
        // Read is issued even when RX is full so the UART flags still clear.
        bus.READ_DATA = 1'b1;
        if (rx_full) err_d[3] = 1'b1;
        state_d = (tx_shadow_q && !tx_empty) ? StTxld : StIdle;
      end
      StTxld: begin
        bus.Tx_load = 1'b1;
        tx_shadow_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new interrupt always wins over the clear on status exit.
    if (bus.UART_INTR) intr_pending_d = 1'b1;
    // Latch the head on entry so OUT_PORT_DATA is valid during the load cycle.
    if (state_d == StTxld) out_data_d = tx_mem[tx_rd_ptr_q];
  end

  // FIFO occupancy and the show-ahead RX head.
  always_comb begin
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    rx_rdata_d = rx_rdata_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
    if (rx_pop) begin
      if (rx_count_q > OneCount) rx_rdata_d = rx_mem[rx_rd_ptr_nxt];
      else if (rx_push)          rx_rdata_d = bus.UART_DATA_OUT;
    end else if (rx_push && rx_empty) begin
      rx_rdata_d = bus.UART_DATA_OUT;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      intr_pending_q <= 1'b1;
      tx_shadow_q    <= 1'b0;
      err_q          <= 4'b0000;
      out_data_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      intr_pending_q <= intr_pending_d;
      tx_shadow_q    <= tx_shadow_d;
      err_q          <= err_d;
      out_data_q     <= out_data_d;
    end
  end

  // FIFO pointers, counts and RX head register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      rx_rdata_q  <= 8'h00;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_nxt;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      rx_rdata_q <= rx_rdata_d;
    end
  end

  // FIFO storage; contents are discarded on reset via the pointers.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.TX_WDATA;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= bus.UART_DATA_OUT;
  end

  assign bus.OUT_PORT_DATA = out_data_q;
  assign bus.TX_FULL       = tx_full;
  assign bus.TX_COUNT      = tx_count_q;
  assign bus.RX_RDATA      = rx_rdata_q;
  assign bus.RX_EMPTY      = rx_empty;
  assign bus.RX_COUNT      = rx_count_q;
  assign bus.ERR_FLAGS     = err_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Bench for uart_host_bridge: directed scenarios plus random traffic, all checked
// every cycle against a queue-based transaction model of the bridge.
module tb_uart_host_bridge;
  localparam int unsigned Depth = 16;
  localparam int unsigned Aw    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_host_bridge_if #(.AW(Aw)) bus ();

  uart_host_bridge #(.DEPTH(Depth), .AW(Aw)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // UART side: the read mux answers whichever strobe the bridge raises.
  logic [7:0] stat_val = 8'h00;
  logic [7:0] rx_val   = 8'h00;
  assign bus.UART_DATA_OUT = bus.READ_STATUS ? stat_val : (bus.READ_DATA ? rx_val : 8'h00);

  int total = 0;
  int bad   = 0;

  // Model: what the UART interface is doing this cycle (0 none, 1 status, 2 data, 3 load).
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] m_out, m_head;
  logic [3:0] m_flags;
  bit         m_pend, m_shadow;
  int         m_act;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int dut_act();
    if (bus.READ_STATUS) return 1;
    if (bus.READ_DATA)   return 2;
    if (bus.Tx_load)     return 3;
    return 0;
  endfunction

  // Advance the model over the coming clock edge using the inputs now applied.
  task automatic model_step();
    logic [7:0] data;
    int nxt, tx_n, rx_n;
    bit rx_chg;
    if (!reset) begin
      txq.delete(); rxq.delete();
      m_out = 8'h00; m_head = 8'h00; m_flags = 4'h0;
      m_pend = 1'b1; m_shadow = 1'b0; m_act = 0;
      return;
    end
    tx_n = txq.size();
    rx_n = rxq.size();
    data = (m_act == 1) ? stat_val : ((m_act == 2) ? rx_val : 8'h00);
    case (m_act)
      0:       nxt = m_pend ? 1 : ((m_shadow && tx_n > 0) ? 3 : 0);
      1:       nxt = data[0] ? 2 : ((data[1] && tx_n > 0) ? 3 : 0);
      2:       nxt = (m_shadow && tx_n > 0) ? 3 : 0;
      default: nxt = 0;
    endcase
    if (bus.ERR_CLR) m_flags = 4'h0;
    if (m_act == 1) m_flags[2:0] = m_flags[2:0] | data[4:2];
    if (m_act == 2 && rx_n == Depth) m_flags[3] = 1'b1;
    if (m_act == 1) m_shadow = data[1];
    else if (m_act == 3) m_shadow = 1'b0;
    if (bus.UART_INTR) m_pend = 1'b1;
    else if (m_act == 1) m_pend = 1'b0;
    if (nxt == 3) m_out = txq[0];
    if (m_act == 3) void'(txq.pop_front());
    if (bus.TX_WR && tx_n < Depth) txq.push_back(bus.TX_WDATA);
    rx_chg = 1'b0;
    if (bus.RX_RD && rx_n > 0) begin
      void'(rxq.pop_front());
      rx_chg = 1'b1;
    end
    if (m_act == 2 && rx_n < Depth) begin
      rxq.push_back(data);
      rx_chg = 1'b1;
    end
    if (rx_chg && rxq.size() > 0) m_head = rxq[0];
    m_act = nxt;
  endtask

  task automatic compare();
    chk("read_status",  bus.READ_STATUS, m_act == 1);
    chk("read_data",    bus.READ_DATA,   m_act == 2);
    chk("tx_load",      bus.Tx_load,     m_act == 3);
    chk("strobe_excl",  ($countones({bus.READ_STATUS, bus.READ_DATA, bus.Tx_load}) <= 1), 1);
    chk("out_port",     bus.OUT_PORT_DATA, m_out);
    chk("tx_count",     bus.TX_COUNT,  txq.size());
    chk("tx_full",      bus.TX_FULL,   txq.size() == Depth);
    chk("rx_count",     bus.RX_COUNT,  rxq.size());
    chk("rx_empty",     bus.RX_EMPTY,  rxq.size() == 0);
    chk("rx_rdata",     bus.RX_RDATA,  m_head);
    chk("err_flags",    bus.ERR_FLAGS, m_flags);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wait_strobe(input int which, input int limit, input string name);
    int n = 0;
    while (dut_act() != which && n < limit) begin
      tick();
      n++;
    end
    chk(name, dut_act(), which);
  endtask

  task automatic pulse_intr();
    bus.UART_INTR = 1'b1;
    tick();
    bus.UART_INTR = 1'b0;
  endtask

  initial begin
    bus.UART_INTR = 1'b0; bus.TX_WR = 1'b0; bus.TX_WDATA = 8'h00;
    bus.RX_RD = 1'b0; bus.ERR_CLR = 1'b0;

    // 1: reset state, forced status read right after release
    stat_val = 8'h02;
    tick(); tick();
    chk("t1 reset rx_rdata", bus.RX_RDATA, 8'h00);
    chk("t1 reset rx_empty", bus.RX_EMPTY, 1);
    chk("t1 reset strobes",  dut_act(), 0);
    reset = 1'b1;
    tick();
    chk("t1 first status", bus.READ_STATUS, 1);
    tick();
    chk("t1 back to idle", dut_act(), 0);
    chk("t1 err clean", bus.ERR_FLAGS, 4'h0);

    // 2: two TX bytes, second load waits for a fresh TX_RDY status
    bus.TX_WR = 1'b1; bus.TX_WDATA = 8'hA5; tick();
    bus.TX_WDATA = 8'h3C; tick();
    bus.TX_WR = 1'b0;
    wait_strobe(3, 4, "t2 first load");
    chk("t2 out A5", bus.OUT_PORT_DATA, 8'hA5);
    chk("t2 count 2", bus.TX_COUNT, 2);
    tick();
    chk("t2 count 1", bus.TX_COUNT, 1);
    repeat (4) tick();
    chk("t2 no second load", bus.Tx_load, 0);
    pulse_intr();
    wait_strobe(1, 4, "t2 status");
    tick();
    chk("t2 second load", bus.Tx_load, 1);
    chk("t2 out 3C", bus.OUT_PORT_DATA, 8'h3C);
    tick();
    chk("t2 count 0", bus.TX_COUNT, 0);

    // 3: single RX byte
    stat_val = 8'h01; rx_val = 8'h5A;
    pulse_intr();
    wait_strobe(1, 4, "t3 status");
    tick();
    chk("t3 read data", bus.READ_DATA, 1);
    tick();
    chk("t3 rx count", bus.RX_COUNT, 1);
    chk("t3 rx head", bus.RX_RDATA, 8'h5A);
    bus.RX_RD = 1'b1; tick(); bus.RX_RD = 1'b0;
    chk("t3 rx empty", bus.RX_EMPTY, 1);

    // 4: RX overflow
    for (int i = 0; i < Depth; i++) begin
      rx_val = 8'(8'h10 + i);
      pulse_intr();
      wait_strobe(2, 6, "t4 fill");
      tick();
    end
    rx_val = 8'hEE;
    pulse_intr();
    wait_strobe(2, 6, "t4 overflow read");
    tick();
    chk("t4 rx count 16", bus.RX_COUNT, 16);
    chk("t4 err ovf", bus.ERR_FLAGS, 4'b1000);
    chk("t4 head", bus.RX_RDATA, 8'h10);
    bus.ERR_CLR = 1'b1; tick(); bus.ERR_CLR = 1'b0;
    chk("t4 err clr", bus.ERR_FLAGS, 4'h0);
    bus.RX_RD = 1'b1; repeat (Depth) tick(); bus.RX_RD = 1'b0;
    chk("t4 drained", bus.RX_EMPTY, 1);

    // 5: error status with TX pending, interrupt during RXRD
    bus.TX_WR = 1'b1; bus.TX_WDATA = 8'h77; tick(); bus.TX_WR = 1'b0;
    stat_val = 8'h1F; rx_val = 8'hC3;
    pulse_intr();
    wait_strobe(1, 4, "t5 status");
    tick();
    chk("t5 rxrd", dut_act(), 2);
    chk("t5 err 0111", bus.ERR_FLAGS, 4'b0111);
    bus.UART_INTR = 1'b1; tick(); bus.UART_INTR = 1'b0;
    chk("t5 txld", dut_act(), 3);
    chk("t5 out 77", bus.OUT_PORT_DATA, 8'h77);
    wait_strobe(1, 3, "t5 restat");
    stat_val = 8'h00;
    repeat (3) tick();
    pulse_intr();
    wait_strobe(1, 4, "t5 clear shadow");
    bus.ERR_CLR = 1'b1; bus.RX_RD = 1'b1; repeat (3) tick();
    bus.ERR_CLR = 1'b0; bus.RX_RD = 1'b0;

    // 6: TX overfill with no TX_RDY, then reset during a load
    for (int i = 0; i < Depth + 1; i++) begin
      bus.TX_WR = 1'b1; bus.TX_WDATA = 8'(8'h80 + i); tick();
    end
    bus.TX_WR = 1'b0;
    chk("t6 full", bus.TX_FULL, 1);
    chk("t6 count 16", bus.TX_COUNT, 16);
    stat_val = 8'h02;
    pulse_intr();
    wait_strobe(3, 6, "t6 load");
    chk("t6 out first", bus.OUT_PORT_DATA, 8'h80);
    reset = 1'b0; tick();
    chk("t6 reset strobes", dut_act(), 0);
    chk("t6 reset txcount", bus.TX_COUNT, 0);
    chk("t6 reset rxcount", bus.RX_COUNT, 0);
    reset = 1'b1;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset         = ($urandom_range(0, 599) != 0);
      bus.UART_INTR = ($urandom_range(0, 5) == 0);
      stat_val      = 8'($urandom_range(0, 31));
      rx_val        = 8'($urandom);
      bus.TX_WR     = ($urandom_range(0, 1) == 0);
      bus.TX_WDATA  = 8'($urandom);
      bus.RX_RD     = ($urandom_range(0, 3) == 0);
      bus.ERR_CLR   = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
